unary_mac_sequencer: RTL and testbench
======================================

Name: unary_mac_sequencer

Overview:
Sequencer that feeds one serial unary multiplier from a binary operand stream and accumulates the results. It takes binary (a, b) pairs over a valid/ready handshake and emits each pair as a pair of contiguous unary pulse trains. It counts the unary product pulses returned by the multiplier, adds each product into a binary accumulator, and presents the dot-product result once the pair tagged last has been accumulated. It sits between the binary-side operand source and the multiplier, and is the only driver of the multiplier's inputs.

Parameters:
BIN_BITS, 4, operand width; operands 0..2^BIN_BITS-1 (must match multiplier).
ACC_BITS, 16, accumulator/result width; must be >= 2*BIN_BITS.
TIMEOUT, 1024, maximum cycles allowed in COLLECT before an abort.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
op_valid  in  1  operand pair valid.
op_ready  out  1  sequencer accepts the pair this cycle.
op_a  in  BIN_BITS  binary operand A.
op_b  in  BIN_BITS  binary operand B.
op_last  in  1  final pair of the current accumulation.
mul_in_a  out  1  serial unary A to multiplier (registered).
mul_in_b  out  1  serial unary B to multiplier (registered).
mul_out  in  1  serial unary product from multiplier.
acc_valid  out  1  result valid.
acc_ready  in  1  consumer takes the result.
acc_out  out  ACC_BITS  accumulated result; held stable while acc_valid.
busy  out  1  high in every state except IDLE.
err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset values: op_ready=0, mul_in_a=0, mul_in_b=0, acc_valid=0, acc_out=0, busy=0, err=0. State is IDLE; accumulator, counters and captured operands are 0.
- A reset asserted mid-operation aborts immediately. Both unary outputs go low in the same cycle. The multiplier shares reset_n, so no drain is needed.
- op_ready=1 only in IDLE. A transfer occurs on op_valid&op_ready. op_a, op_b, op_last and the expected product P=op_a*op_b (2*BIN_BITS bits) are captured.
- States: IDLE, STREAM, GAP, COLLECT, SETTLE, EMIT.
- IDLE -> STREAM on transfer. If op_a==0 and op_b==0, go instead to SETTLE with product 0.
- STREAM:
  - Lasts max(a,b) cycles; mul_in_a=1 for the first a cycles and mul_in_b=1 for the first b cycles.
  - Both trains start in the same cycle, are contiguous, and never restart.
  - mul_in_a and mul_in_b are low outside STREAM.
- GAP: one cycle with both inputs low (end-of-operand marker), then -> COLLECT.
- COLLECT:
  - A 2*BIN_BITS count register increments on each cycle with mul_out=1. Leave when count==P, or immediately when P==0. mul_out pulses counted in GAP also count.
  - Add P (zero-extended) to the accumulator, saturating at 2^ACC_BITS-1, then -> SETTLE.
  - Timeout counter: if TIMEOUT cycles elapse without count reaching P, set err, skip the add and -> SETTLE.
- SETTLE: exactly 2 cycles with inputs low so the multiplier returns to its idle state.
  - Then -> EMIT if the captured last==1.
  - Otherwise -> IDLE.
- EMIT:
  - acc_valid=1 and acc_out=accumulator.
  - On acc_ready: clear the accumulator and -> IDLE in the next cycle.
  - Without acc_ready, hold indefinitely with no new op accepted.
- mul_out pulses outside COLLECT/GAP are ignored.
- err stays set after a timeout; operation continues normally afterwards.
- Latency per pair, from transfer to return to IDLE: 1 + max(a,b) + 1 + (collect cycles) + 2.

Test Plan:
1. Single pair a=3, b=5, last=1, with a model multiplier returning 15 pulses -> mul_in_a high for 3 cycles and mul_in_b for 5 from the same edge; acc_valid with acc_out=15; accumulator cleared after acc_ready.
2. Four pairs (2,3), (15,15), (0,7), (1,1), last on the fourth -> acc_out=6+225+0+1=232; op_ready low between pairs until SETTLE completes.
3. Pair (0,0) -> no unary pulse on mul_in_a/mul_in_b; product 0 accumulated; SETTLE entered directly.
4. acc_ready held low for 10 cycles in EMIT with op_valid=1 -> acc_out stable, op_ready=0, no transfer; release -> next op accepted in the following IDLE cycle.
5. Model multiplier stalls (mul_out stuck 0) with a=2, b=2 -> err=1 after TIMEOUT cycles; accumulator unchanged; the next pair (1,1,last) yields acc_out=1 with err still 1.
6. reset_n pulsed low mid-STREAM (a=9, b=9, cycle 4) -> mul_in_a/mul_in_b low within the same cycle; all outputs at reset values; the next pair runs normally.

Source files
------------

// File: rtl/unary_mac_sequencer.sv
// Sequencer between a binary operand stream and a serial unary multiplier:
// emits each (a, b) pair as unary pulse trains, counts product pulses and accumulates.
module unary_mac_sequencer #(
  parameter int BIN_BITS = 4,
  parameter int ACC_BITS = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [BIN_BITS-1:0] op_a,
  input  logic [BIN_BITS-1:0] op_b,
  input  logic                op_last,
  output logic                mul_in_a,
  output logic                mul_in_b,
  input  logic                mul_out,
  output logic                acc_valid,
  input  logic                acc_ready,
  output logic [ACC_BITS-1:0] acc_out,
  output logic                busy,
  output logic                err
);

  localparam int PBITS = 2 * BIN_BITS;
  localparam int TBITS = $clog2(TIMEOUT + 1);
  localparam logic [TBITS-1:0] TMO_LAST = TBITS'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, STREAM, GAP, COLLECT, SETTLE, EMIT} state_t;

  state_t              state_q, state_d;
  logic [BIN_BITS-1:0] a_q, a_d, b_q, b_d, step_q, step_d;
  logic                last_q, last_d;
  logic [PBITS-1:0]    prod_q, prod_d, cnt_q, cnt_d;
  logic [TBITS-1:0]    tmo_q, tmo_d;
  logic                settle_q, settle_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic                err_q, err_d;
  logic                mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic                op_ready_q, acc_valid_q, busy_q;

  logic                xfer;
  logic [BIN_BITS-1:0] len;
  logic [BIN_BITS:0]   step_nxt;
  logic [PBITS-1:0]    cnt_inc;
  logic [ACC_BITS:0]   acc_sum;

  assign xfer     = op_valid & op_ready_q;
  assign len      = (a_q > b_q) ? a_q : b_q;
  assign step_nxt = {1'b0, step_q} + {{BIN_BITS{1'b0}}, 1'b1};
  assign cnt_inc  = cnt_q + {{(PBITS-1){1'b0}}, mul_out};
  assign acc_sum  = {1'b0, acc_q} + {{(ACC_BITS+1-PBITS){1'b0}}, prod_q};

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    step_d   = step_q;
    last_d   = last_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    settle_d = settle_q;
    acc_d    = acc_q;
    err_d    = err_q;
    mul_a_d  = 1'b0;
    mul_b_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          a_d    = op_a;
          b_d    = op_b;
          last_d = op_last;
          prod_d = {{BIN_BITS{1'b0}}, op_a} * {{BIN_BITS{1'b0}}, op_b};
          cnt_d  = '0;
          step_d = '0;
          tmo_d  = '0;
          if (op_a == '0 && op_b == '0) begin
            state_d  = SETTLE;
            settle_d = 1'b0;
          end else begin
            state_d = STREAM;
            mul_a_d = (op_a != '0);
            mul_b_d = (op_b != '0);
          end
        end
      end
      STREAM: begin
        // Unary outputs are registered, so each bit is decided for the upcoming cycle index.
        if (step_nxt < {1'b0, len}) begin
          step_d  = step_nxt[BIN_BITS-1:0];
          mul_a_d = (step_nxt < {1'b0, a_q});
          mul_b_d = (step_nxt < {1'b0, b_q});
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d   = cnt_inc;
        tmo_d   = '0;
        state_d = COLLECT;
      end
      COLLECT: begin
        cnt_d = cnt_inc;
        if (prod_q == '0 || cnt_inc == prod_q) begin
          acc_d    = acc_sum[ACC_BITS] ? {ACC_BITS{1'b1}} : acc_sum[ACC_BITS-1:0];
          state_d  = SETTLE;
          settle_d = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          err_d    = 1'b1;
          state_d  = SETTLE;
          settle_d = 1'b0;
        end else begin
          tmo_d = tmo_q + {{(TBITS-1){1'b0}}, 1'b1};
        end
      end
      SETTLE: begin
        if (settle_q) state_d = last_q ? EMIT : IDLE;
        else          settle_d = 1'b1;
      end
      EMIT: begin
        if (acc_ready) begin
          acc_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state, including the datapath registers, is cleared by the async reset
  // so a mid-operation reset leaves no stale operands or partial sums behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      step_q      <= '0;
      last_q      <= 1'b0;
      prod_q      <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      settle_q    <= 1'b0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      mul_a_q     <= 1'b0;
      mul_b_q     <= 1'b0;
      op_ready_q  <= 1'b0;
      acc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      step_q      <= step_d;
      last_q      <= last_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      settle_q    <= settle_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      op_ready_q  <= (state_d == IDLE);
      acc_valid_q <= (state_d == EMIT);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign op_ready  = op_ready_q;
  assign mul_in_a  = mul_a_q;
  assign mul_in_b  = mul_b_q;
  assign acc_valid = acc_valid_q;
  assign acc_out   = acc_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_unary_mac_sequencer.sv
// Self-checking bench for unary_mac_sequencer: model unary multiplier, directed
// and random operand pairs, dot-product reference computed with plain arithmetic.
module tb_unary_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid, op_ready, op_last;
  logic [3:0]  op_a, op_b;
  logic        mul_in_a, mul_in_b, mul_out;
  logic        acc_valid, acc_ready;
  logic [15:0] acc_out;
  logic        busy, err;

  int errors = 0;
  int checks = 0;
  int unsigned acc_model = 0;
  bit          err_model = 0;

  // Model multiplier / stream monitor state
  int unsigned na, nb, pend, runs = 0;
  bit active, stall, first_a, first_b, fell_a, fell_b, shape_ok;

  always #5 clk = ~clk;

  unary_mac_sequencer #(.BIN_BITS(4), .ACC_BITS(16), .TIMEOUT(1024)) dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_last(op_last),
    .mul_in_a(mul_in_a), .mul_in_b(mul_in_b), .mul_out(mul_out),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_out(acc_out),
    .busy(busy), .err(err)
  );

  // Unary multiplier model: counts the two input trains, then after the
  // end-of-operand gap returns a*b pulses with random idle cycles in between.
  initial begin
    mul_out = 1'b0;
    active = 0; pend = 0; na = 0; nb = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        active = 0; pend = 0; na = 0; nb = 0; mul_out = 1'b0;
      end else begin
        if (mul_in_a || mul_in_b) begin
          if (!active) begin
            active = 1; na = 0; nb = 0;
            first_a = mul_in_a; first_b = mul_in_b;
            fell_a = 0; fell_b = 0; shape_ok = 1;
          end
          if (mul_in_a) begin if (fell_a) shape_ok = 0; na++; end else fell_a = 1;
          if (mul_in_b) begin if (fell_b) shape_ok = 0; nb++; end else fell_b = 1;
        end else if (active) begin
          active = 0;
          runs++;
          if (!stall) pend = na * nb;
        end
        if (pend > 0 && $urandom_range(0, 3) != 0) begin
          mul_out = 1'b1;
          pend--;
        end else begin
          mul_out = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned sat_add(input int unsigned x, input int unsigned y);
    return (x + y > 65535) ? 65535 : x + y;
  endfunction

  // Called at the first point after the transfer edge; waits for the pair to finish.
  task automatic finish_pair(input int a, input int b, input bit last, input bit stalled,
                             input int unsigned runs0, input string tag);
    int n;
    @(negedge clk);
    check({tag, " busy"}, busy, 1);
    check({tag, " op_ready low"}, op_ready, 0);
    if (stalled && a * b != 0) err_model = 1;
    else acc_model = sat_add(acc_model, a * b);
    n = 0;
    while (!(op_ready || acc_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done"}, op_ready || acc_valid, 1);
    if (a == 0 && b == 0) begin
      check({tag, " no trains"}, runs, runs0);
      check({tag, " latency"}, n + 1, 3);
    end else begin
      check({tag, " one train"}, runs, runs0 + 1);
      check({tag, " len a"}, na, a);
      check({tag, " len b"}, nb, b);
      check({tag, " start a"}, first_a, a != 0);
      check({tag, " start b"}, first_b, b != 0);
      check({tag, " contiguous"}, shape_ok, 1);
    end
    check({tag, " acc_valid"}, acc_valid, last);
    check({tag, " err"}, err, err_model);
    if (last) check({tag, " acc_out"}, acc_out, acc_model);
  endtask

  task automatic run_pair(input int a, input int b, input bit last, input bit stalled,
                          input string tag);
    int n;
    int unsigned runs0;
    stall = stalled;
    n = 0;
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready"}, op_ready, 1);
    runs0 = runs;
    op_a = 4'(a); op_b = 4'(b); op_last = last; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    finish_pair(a, b, last, stalled, runs0, tag);
  endtask

  task automatic release_result(input string tag);
    acc_ready = 1'b1;
    @(posedge clk);
    #1 acc_ready = 1'b0;
    acc_model = 0;
    @(negedge clk);
    check({tag, " valid dropped"}, acc_valid, 0);
    check({tag, " acc cleared"}, acc_out, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int a, b;
    int unsigned runs0;
    reset_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; op_last = 1'b0;
    acc_ready = 1'b0; stall = 0;
    #1;
    check("rst op_ready", op_ready, 0);
    check("rst mul_in_a", mul_in_a, 0);
    check("rst mul_in_b", mul_in_b, 0);
    check("rst acc_valid", acc_valid, 0);
    check("rst acc_out", acc_out, 0);
    check("rst busy", busy, 0);
    check("rst err", err, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Single pair 3x5
    run_pair(3, 5, 1, 0, "t1");
    release_result("t1");

    // Four-pair dot product: 6 + 225 + 0 + 1 = 232
    run_pair(2, 3, 0, 0, "t2a");
    run_pair(15, 15, 0, 0, "t2b");
    run_pair(0, 7, 0, 0, "t2c");
    run_pair(1, 1, 1, 0, "t2d");
    check("t2 sum", acc_out, 232);
    release_result("t2");

    // Zero pair goes straight to SETTLE
    run_pair(0, 0, 0, 0, "t3a");
    run_pair(2, 2, 1, 0, "t3b");
    release_result("t3");

    // Result held in EMIT while the consumer stalls and a new op waits
    run_pair(4, 6, 1, 0, "t4a");
    op_a = 4'd5; op_b = 4'd3; op_last = 1'b1; op_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4 hold acc_out", acc_out, 24);
      check("t4 hold op_ready", op_ready, 0);
      check("t4 hold acc_valid", acc_valid, 1);
    end
    acc_ready = 1'b1;
    @(posedge clk);
    #1 acc_ready = 1'b0;
    acc_model = 0;
    runs0 = runs;
    @(negedge clk);
    check("t4 released valid", acc_valid, 0);
    check("t4 released acc", acc_out, 0);
    check("t4 idle ready", op_ready, 1);
    @(posedge clk);
    #1 op_valid = 1'b0;
    finish_pair(5, 3, 1, 0, runs0, "t4b");
    release_result("t4");

    // Stalled multiplier -> timeout, accumulator untouched, err sticky
    run_pair(2, 2, 0, 1, "t5a");
    run_pair(1, 1, 1, 0, "t5b");
    release_result("t5");

    // Random pairs
    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      run_pair(a, b, i == 5, 0, "rnd");
    end
    release_result("rnd");

    // Reset mid-STREAM
    stall = 0;
    n = 0;
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    op_a = 4'd9; op_b = 4'd9; op_last = 1'b1; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("t6 pre-reset stream", mul_in_a & mul_in_b, 1);
    reset_n = 1'b0;
    #1;
    check("t6 mul_in_a", mul_in_a, 0);
    check("t6 mul_in_b", mul_in_b, 0);
    check("t6 op_ready", op_ready, 0);
    check("t6 busy", busy, 0);
    check("t6 acc_valid", acc_valid, 0);
    check("t6 acc_out", acc_out, 0);
    check("t6 err", err, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    acc_model = 0;
    err_model = 0;
    run_pair(9, 9, 1, 0, "t6b");
    release_result("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
